// File: rtl/swap_cmd_sched.sv
// -----------------------------------------------------------------------------
// swap_cmd_sched
//
// Queues swap requests {addr_a, addr_b} in a small FIFO and issues them one at
// a time to a downstream swap register file. Each swap sends a one-cycle swap
// pulse with the two addresses. The block then waits SWAP_CYCLES cycles before
// it retires the request with a one-cycle done pulse. A request whose two
// addresses are equal is retired as a no-op: no swap pulse is sent and the
// address outputs are left unchanged.
//
// Ports
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   req_valid   : a request is offered
//   req_ready   : a request can be accepted (FIFO not full)
//   req_addr_a  : first swap address of the offered request
//   req_addr_b  : second swap address of the offered request
//   swap        : one-cycle start pulse to the swap register file
//   address_A   : address A to the swap register file
//   address_B   : address B to the swap register file
//   busy        : a swap is in flight (ISSUE or WAIT)
//   done        : one-cycle pulse when a request retires (swap or no-op)
//   swap_count  : number of swaps issued, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module swap_cmd_sched #(
  parameter int ADDR_WIDTH  = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int SWAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  output logic                  swap,
  output logic [ADDR_WIDTH-1:0] address_A,
  output logic [ADDR_WIDTH-1:0] address_B,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           swap_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SWAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] b;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic [PTR_W:0]   occ_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  entry_t           head;

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  // The ready signal looks only at the registered occupancy. A pop in the same
  // cycle frees its slot one edge later, so it does not raise ready.
  assign req_ready  = ~fifo_full;
  assign push       = req_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: the storage array has no reset. Only the pointers and the occupancy
  // define which entries are valid, so stale data is never observed, and the
  // array can map onto plain RAM or flops without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_t'{a: req_addr_a, b: req_addr_b};
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM and output registers
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  swap_q, done_q, done_d;
  logic [15:0]           swap_count_q, swap_count_d;

  // NOTE: every combinational output gets a default before the case. Then no
  // path leaves a variable unassigned, and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.a == head.b) begin
            // Swapping a register with itself is a no-op: retire it at once
            // and leave the address outputs untouched.
            done_d = 1'b1;
          end else begin
            addr_a_d = head.a;
            addr_b_d = head.b;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    swap_count_d = swap_count_q;
    if ((state_q == ST_ISSUE) && (swap_count_q != 16'hFFFF)) begin
      swap_count_d = swap_count_q + 16'd1;
    end
  end

  // NOTE: state elements use non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      swap_q       <= 1'b0;
      done_q       <= 1'b0;
      swap_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      // The swap flop is loaded from the next-state decode, so the pulse comes
      // straight from a register and lines up with the ISSUE cycle.
      swap_q       <= (state_d == ST_ISSUE);
      done_q       <= done_d;
      swap_count_q <= swap_count_d;
      occ_q        <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign swap       = swap_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign address_A  = addr_a_q;
  assign address_B  = addr_b_q;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_swap_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_swap_cmd_sched
//
// Randomized and directed stimulus for swap_cmd_sched. The reference model
// keeps a queue of pending requests and a job timer: cycles elapsed since the
// active request was popped. Time 0 is the swap cycle, times 1..SWAP_CYCLES
// are the wait, and retirement comes one cycle later.
// -----------------------------------------------------------------------------
module tb_swap_cmd_sched;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int SW    = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr_a;
  logic [AW-1:0] req_addr_b;
  logic          swap;
  logic [AW-1:0] address_A;
  logic [AW-1:0] address_B;
  logic          busy;
  logic          done;
  logic [15:0]   swap_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  swap_cmd_sched #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .SWAP_CYCLES(SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr_a(req_addr_a),
    .req_addr_b(req_addr_b),
    .swap      (swap),
    .address_A (address_A),
    .address_B (address_B),
    .busy      (busy),
    .done      (done),
    .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  pair_t         mq[$];
  int            m_t;      // -1 when idle, otherwise cycles since the pop
  logic [AW-1:0] m_a, m_b;
  logic [15:0]   m_cnt;
  logic          m_done;
  logic          m_acc;    // the last edge accepted a request

  logic [33:0] act_vec;
  assign act_vec = {swap, done, busy, req_ready, address_A, address_B, swap_count};

  function automatic logic [33:0] exp_vec();
    return {(m_t == 0), m_done, (m_t >= 0), (mq.size() < DEPTH), m_a, m_b, m_cnt};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_t    = -1;
    m_a    = '0;
    m_b    = '0;
    m_cnt  = '0;
    m_done = 1'b0;
    m_acc  = 1'b0;
  endtask

  // One rising edge of the model, evaluated from the pre-edge state.
  task automatic model_edge();
    logic  pop_ok, dn;
    pair_t h;
    m_acc  = req_valid && (mq.size() < DEPTH);
    pop_ok = (m_t < 0) && (mq.size() > 0);
    dn     = 1'b0;
    if (m_t == 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_t >= 0) begin
      if (m_t == SW) begin
        m_t = -1;
        dn  = 1'b1;
      end else begin
        m_t = m_t + 1;
      end
    end
    if (pop_ok) begin
      h = mq.pop_front();
      if (h.a == h.b) begin
        dn = 1'b1;
      end else begin
        m_t = 0;
        m_a = h.a;
        m_b = h.b;
      end
    end
    if (m_acc) mq.push_back(pair_t'{a: req_addr_a, b: req_addr_b});
    m_done = dn;
  endtask

  // Advance one clock; leave the bench at the following falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic model_quiet();
    return (m_t < 0) && (mq.size() == 0) && !m_done;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr_a = '0;
    req_addr_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", act_vec, exp_vec());
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || swap_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: ready %b busy %b count %h want 1 0 0000",
               req_ready, busy, swap_count);
    end
  endtask

  task automatic test_single_swap();
    int n_swap, t_swap, t_done;
    n_swap = 0; t_swap = -1; t_done = -1;
    req_valid = 1'b1; req_addr_a = 7'd3; req_addr_b = 7'd9;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < SW + 6; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_swap cyc %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (swap === 1'b1) begin n_swap++; t_swap = i; end
      if (done === 1'b1) t_done = i;
    end
    checks++;
    if (n_swap != 1 || t_swap != 0 || t_done != SW + 1 || swap_count !== 16'd1) begin
      errors++;
      $display("FAIL single_swap_timing: swaps %0d at %0d done at %0d count %0d want 1 0 %0d 1",
               n_swap, t_swap, t_done, swap_count, SW + 1);
    end
    checks++;
    if (address_A !== 7'd3 || address_B !== 7'd9) begin
      errors++;
      $display("FAIL single_swap_addr: got %0d,%0d want 3,9", address_A, address_B);
    end
  endtask

  task automatic test_noop();
    logic [AW-1:0] pa, pb;
    logic [15:0]   pc;
    int n_swap, t_done;
    pa = m_a; pb = m_b; pc = m_cnt;
    n_swap = 0; t_done = -1;
    req_valid = 1'b1; req_addr_a = 7'd5; req_addr_b = 7'd5;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL noop cyc %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (swap === 1'b1) n_swap++;
      if (done === 1'b1) t_done = i;
    end
    checks++;
    if (n_swap != 0 || t_done != 0 || swap_count !== pc || address_A !== pa || address_B !== pb) begin
      errors++;
      $display("FAIL noop_effect: swaps %0d done at %0d count %0d addr %0d,%0d want 0 0 %0d %0d,%0d",
               n_swap, t_done, swap_count, address_A, address_B, pc, pa, pb);
    end
  endtask

  task automatic test_full_fifo();
    int            acc_n, guard;
    int            t_sw[$];
    logic [AW-1:0] sa[$], sb[$];
    logic          saw_full;
    acc_n = 0; guard = 0; saw_full = 1'b0;
    req_valid = 1'b1; req_addr_a = 7'd1; req_addr_b = 7'd2;
    while (guard < 200 && (acc_n < 5 || !model_quiet())) begin
      step();
      guard++;
      if (m_acc) begin
        acc_n++;
        req_addr_a = AW'(2 * acc_n + 1);
        req_addr_b = AW'(2 * acc_n + 2);
      end
      if (acc_n >= 5) req_valid = 1'b0;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL full_fifo cyc %0d: got %h want %h", guard, act_vec, exp_vec());
      end
      if (req_ready === 1'b0) saw_full = 1'b1;
      if (swap === 1'b1) begin
        t_sw.push_back(cyc);
        sa.push_back(address_A);
        sb.push_back(address_B);
      end
    end
    checks++;
    if (guard >= 200 || t_sw.size() != 5 || !saw_full) begin
      errors++;
      $display("FAIL full_fifo_count: guard %0d swaps %0d saw_full %b want <200 5 1",
               guard, t_sw.size(), saw_full);
    end
    for (int i = 0; i < t_sw.size(); i++) begin
      checks++;
      if (sa[i] !== AW'(2 * i + 1) || sb[i] !== AW'(2 * i + 2)) begin
        errors++;
        $display("FAIL full_fifo_order %0d: got %0d,%0d want %0d,%0d",
                 i, sa[i], sb[i], 2 * i + 1, 2 * i + 2);
      end
      if (i > 0) begin
        checks++;
        if (t_sw[i] - t_sw[i-1] != SW + 2) begin
          errors++;
          $display("FAIL full_fifo_gap %0d: got %0d want %0d", i, t_sw[i] - t_sw[i-1], SW + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    guard = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid  = 1'b1;
      req_addr_a = AW'(20 + 2 * i);
      req_addr_b = AW'(21 + 2 * i);
      step();
    end
    req_valid = 1'b0;
    while (m_t != 2 && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 20 || mq.size() != 2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midwait_setup: guard %0d queued %0d busy %b want <20 2 1",
               guard, mq.size(), busy);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL midwait_async: got %h want %h", act_vec, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL midwait_hold %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < SW + 4; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec() || done !== 1'b0 || swap !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL midwait_after %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int guard;
    force dut.swap_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step();
    release dut.swap_count_q;
    #1;
    checks++;
    if (swap_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h want fffe", swap_count);
    end
    for (int i = 0; i < 3; i++) begin
      req_valid  = 1'b1;
      req_addr_a = AW'(40 + i);
      req_addr_b = AW'(60 + i);
      step();
      req_valid = 1'b0;
      guard = 0;
      while (!model_quiet() && guard < 30) begin
        step();
        guard++;
        checks++;
        if (act_vec !== exp_vec()) begin
          errors++;
          $display("FAIL saturation swap %0d: got %h want %h", i, act_vec, exp_vec());
        end
      end
    end
    repeat (3) step();
    checks++;
    if (swap_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h want ffff", swap_count);
    end
  endtask

  task automatic test_wrap();
    int            guard, n_seen;
    logic [AW-1:0] a, b;
    for (int k = 0; k < 10; k++) begin
      a = AW'($urandom_range(0, 127));
      b = a + AW'($urandom_range(1, 127));
      req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
      step();
      req_valid = 1'b0;
      guard = 0; n_seen = 0;
      while (!model_quiet() && guard < 30) begin
        step();
        guard++;
        checks++;
        if (act_vec !== exp_vec() || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL wrap %0d: got %h want %h", k, act_vec, exp_vec());
        end
        if (swap === 1'b1) begin
          n_seen++;
          checks++;
          if (address_A !== a || address_B !== b) begin
            errors++;
            $display("FAIL wrap_addr %0d: got %0d,%0d want %0d,%0d", k, address_A, address_B, a, b);
          end
        end
      end
      checks++;
      if (n_seen != 1 || guard >= 30) begin
        errors++;
        $display("FAIL wrap_pulse %0d: swaps %0d guard %0d want 1 <30", k, n_seen, guard);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 2) == 0);
      req_addr_a = AW'($urandom);
      req_addr_b = ($urandom_range(0, 3) == 0) ? req_addr_a : AW'($urandom);
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        if (errors < 30)
          $display("FAIL random cyc %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_swap();
    test_noop();
    test_full_fifo();
    test_reset_mid_wait();
    test_saturation();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
